alu_exec_stage: RTL and testbench

Registered execute stage sitting directly downstream of the ALU control decoder. Consumes the 4-bit ALU control code plus two operands under a valid/ready handshake. Computes the result and registers it with zero/overflow flags into a single-entry output buffer for the memory/writeback stage. An optional iterative multiplier adds a multi-cycle path.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_iter_mul.sv | 62 ++++++
 rtl/alu_exec_stage.sv | 145 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding.
// The ALU control decoder imports the same code constants.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_e;

    function automatic logic is_sub(input logic [3:0] code);
        return code == ALU_SUB;
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Shift-add iterative multiplier: loads on start, then runs one step per active cycle.
// done_c/product_c present the final low-WIDTH product on the last iteration.
module alu_iter_mul #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             active,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done_c,
    output logic [WIDTH-1:0] product_c
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addend_c;

    // Accumulator value after this cycle's step; also the final product on the last step.
    assign addend_c  = mplier_q[0] ? mcand_q : '0;
    assign product_c = acc_q + addend_c;
    assign done_c    = active && (cnt_q == CNT_W'(MUL_CYCLES - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (active) begin
            acc_d    = product_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a single-entry result buffer and valid/ready handshake.
// Define ALU_EXEC_MUL_EN to add the iterative multiplier (code 1000); otherwise 1000 runs as ADD.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic             accept_c;
    logic             is_mul_c;
    logic [WIDTH-1:0] b_eff_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ovf_c;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_product_c;

    // Pass-through ready: a draining result frees the buffer in the same cycle.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

`ifdef ALU_EXEC_MUL_EN
    assign is_mul_c = (alu_ctrl == ALU_MUL);

    alu_iter_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_iter_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept_c && is_mul_c),
        .active    (state_q == ST_MUL_BUSY),
        .op_a      (op_a),
        .op_b      (op_b),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );
`else
    assign is_mul_c      = 1'b0;
    assign mul_done_c    = 1'b0;
    assign mul_product_c = '0;
`endif

    // Single-cycle ALU; SUB reuses the adder as a + ~b + 1, unknown codes fall through to ADD.
    always_comb begin
        b_eff_c   = is_sub(alu_ctrl) ? ~op_b : op_b;
        sum_c     = op_a + b_eff_c + WIDTH'(is_sub(alu_ctrl));
        alu_res_c = sum_c;
        alu_ovf_c = (op_a[WIDTH-1] == b_eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != op_a[WIDTH-1]);
        case (alu_ctrl)
            ALU_AND: begin
                alu_res_c = op_a & op_b;
                alu_ovf_c = 1'b0;
            end
            ALU_OR: begin
                alu_res_c = op_a | op_b;
                alu_ovf_c = 1'b0;
            end
            ALU_SLT: begin
                alu_res_c = WIDTH'($signed(op_a) < $signed(op_b));
                alu_ovf_c = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c) begin
                        state_d = ST_MUL_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res_c;
                        zero_d      = (alu_res_c == '0);
                        overflow_d  = alu_ovf_c;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done_c) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_product_c;
                    zero_d      = (mul_product_c == '0);
                    overflow_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, handshake/reset corner
// sequences, and randomized traffic scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_exec_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned MC = W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_ctrl  = 4'd0;
    logic [W-1:0] op_a      = '0;
    logic [W-1:0] op_b      = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         o;
    } exp_t;

    typedef struct {
        string        name;
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         o;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    alu_exec_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: signed values as 64-bit integers, overflow = true result out of signed range.
    function automatic exp_t ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, t, maxs, mins;
        longint unsigned pa, pb;
        exp_t            e;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxs = (longint'(1) <<< (W - 1)) - 1;
        mins = -(longint'(1) <<< (W - 1));
        t    = sa + sb;
        e.res = W'(t);
        e.o   = (t > maxs) || (t < mins);
        case (c)
            4'b0000: begin e.res = a & b; e.o = 1'b0; end
            4'b0001: begin e.res = a | b; e.o = 1'b0; end
            4'b0110: begin
                t     = sa - sb;
                e.res = W'(t);
                e.o   = (t > maxs) || (t < mins);
            end
            4'b0111: begin e.res = (sa < sb) ? W'(1) : W'(0); e.o = 1'b0; end
`ifdef ALU_EXEC_MUL_EN
            4'b1000: begin
                pa    = 64'(a);
                pb    = 64'(b);
                e.res = W'(pa * pb);
                e.o   = 1'b0;
            end
`endif
            default: ;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic vec_t mk(input string n, input logic [3:0] c, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                                input logic o);
        vec_t v;
        v.name = n; v.ctrl = c; v.a = a; v.b = b; v.res = r; v.z = z; v.o = o;
        return v;
    endfunction

    task automatic drive(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    function automatic logic [3:0] rand_code();
        case ($urandom_range(0, 7))
            0:       return 4'b0000;
            1:       return 4'b0001;
            2, 7:    return 4'b0010;
            3, 6:    return 4'b0110;
            4:       return 4'b0111;
            default: return 4'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard: every accepted request queues its expected result; outputs checked while valid.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                chk("rand_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("rand_out", 64'({result, zero, overflow}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(alu_ctrl, op_a, op_b));
        end
    end

`ifdef ALU_EXEC_MUL_EN
    task automatic mul_seq(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic ez);
        bit bad = 1'b0;
        @(posedge clk); #1; drive(4'b1000, a, b);
        @(negedge clk); chk($sformatf("%s_rdy", nm), 64'(in_ready), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        for (int k = 1; k <= int'(MC); k++) begin
            @(negedge clk);
            if (out_valid || in_ready) bad = 1'b1;
        end
        chk($sformatf("%s_busy", nm), 64'(bad), 64'd0);
        @(negedge clk);
        chk($sformatf("%s_vld", nm), 64'(out_valid), 64'd1);
        chk($sformatf("%s_res", nm), 64'({result, zero, overflow}), 64'({er, ez, 1'b0}));
    endtask
`endif

    initial begin
        bit took;
        bit bad;

        vecs.push_back(mk("add_5_7",   4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0));
        vecs.push_back(mk("sub_9_9",   4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0));
        vecs.push_back(mk("and",       4'b0000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0));
        vecs.push_back(mk("or",        4'b0001, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FFF0,  1'b0, 1'b0));
        vecs.push_back(mk("slt_m1_1",  4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0));
        vecs.push_back(mk("slt_1_m1",  4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0));
        vecs.push_back(mk("add_ovf",   4'b0010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1));
        vecs.push_back(mk("sub_ovf",   4'b0110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1));
        vecs.push_back(mk("sub_0_1",   4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0));
        vecs.push_back(mk("add_wrap",  4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0));
        vecs.push_back(mk("code_0101", 4'b0101, 32'd3,          32'd4,          32'd7,          1'b0, 1'b0));
        vecs.push_back(mk("and_ovf0",  4'b0000, 32'h8000_0000,  32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0));
`ifndef ALU_EXEC_MUL_EN
        vecs.push_back(mk("mul_as_add", 4'b1000, 32'd6,         32'd7,          32'd13,         1'b0, 1'b0));
`endif

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_flags", 64'({zero, overflow}), 64'd0);
        rst_n = 1'b1;
        #1 chk("rst_rdy", 64'(in_ready), 64'd1);

        // Directed vectors, one cycle latency each.
        foreach (vecs[i]) begin
            @(posedge clk); #1; drive(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            @(negedge clk); chk($sformatf("%s_rdy", vecs[i].name), 64'(in_ready), 64'd1);
            @(posedge clk); #1; in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_vld", vecs[i].name), 64'(out_valid), 64'd1);
            chk($sformatf("%s_res", vecs[i].name), 64'(result), 64'(vecs[i].res));
            chk($sformatf("%s_zero", vecs[i].name), 64'(zero), 64'(vecs[i].z));
            chk($sformatf("%s_ovf", vecs[i].name), 64'(overflow), 64'(vecs[i].o));
        end

        // Backpressure: result held, request stalled, then drain+accept in one cycle.
        @(posedge clk); #1; out_ready = 1'b0; drive(4'b0010, 32'd1, 32'd2);
        @(posedge clk); #1; drive(4'b0110, 32'd30, 32'd10);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!out_valid || result !== 32'd3 || in_ready) bad = 1'b1;
            if (k < 3) begin @(posedge clk); #1; end
        end
        chk("bp_hold", 64'(bad), 64'd0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); chk("bp_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_vld", 64'(out_valid), 64'd1);
        chk("bp_next_res", 64'(result), 64'd20);
        @(negedge clk);
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_keep_res", 64'(result), 64'd20);

        // Reset while a result is being held.
        @(posedge clk); #1; out_ready = 1'b0; drive(4'b0010, 32'd3, 32'd4);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk("rst2_pre_vld", 64'(out_valid), 64'd1);
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        chk("rst2_vld", 64'(out_valid), 64'd0);
        chk("rst2_res", 64'({result, zero, overflow}), 64'd0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("rst2_rdy", 64'(in_ready), 64'd1);

`ifdef ALU_EXEC_MUL_EN
        mul_seq("mul_6_7", 32'd6, 32'd7, 32'd42, 1'b0);
        mul_seq("mul_ff_2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
        mul_seq("mul_0_n", 32'd0, 32'h1234_5678, 32'd0, 1'b1);

        // Reset during MUL_BUSY aborts the multiply.
        @(posedge clk); #1; drive(4'b1000, 32'd6, 32'd7);
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mul_vld", 64'(out_valid), 64'd0);
        chk("rst_mul_res", 64'({result, zero, overflow}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_mul_rdy", 64'(in_ready), 64'd1);
        bad = 1'b0;
        for (int k = 0; k < int'(MC) + 4; k++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("rst_mul_abort", 64'(bad), 64'd0);
        mul_seq("mul_after_rst", 32'd6, 32'd7, 32'd42, 1'b0);
`endif

        // Randomized traffic with random backpressure; upstream holds stalled requests.
        mon_en = 1'b1;
        took   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || took) begin
                if ($urandom_range(0, 2) == 0) in_valid = 1'b0;
                else drive(rand_code(), rand_opnd(), rand_opnd());
            end
            @(negedge clk);
            took = in_valid && in_ready;
        end
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("rand_drain", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
